// File: rtl/relu_pool2x2_v2.sv
// relu_pool2x2_v2 -- streaming ReLU followed by 2x2/stride-2 pooling.
//
// The input is a channel-interleaved pixel stream (ch0..chN-1 per pixel).
// Each pooled pixel is emitted 2 clk after the odd-row, odd-col input beat.
// Each input sample is first clamped to [0, MAX_DATA].
// Horizontal pairs are combined in a per-channel hold register.
// Vertical pairs are combined through a one-line buffer. Even rows write it.
// Odd rows read it.
// mode: 0 = max pool, 1 = average pool (sum of four, >> 2).
//
// Ports
//   clk, reset            clock, async active-high reset
//   mode_i                pool mode, latched on the sof_i beat
//   data_i, valid_i       signed input sample and its qualifier (no backpressure)
//   sop_i/eop_i/sof_i/eof_i  line/frame markers, qualified by valid_i
//   data_o, data_valid_o  pooled unsigned sample and qualifier
//   sop_o/eop_o/sof_o/eof_o  output line/frame markers
//   frm_err_o             one-cycle pulse on a framing violation
module relu_pool2x2_v2 #(
    parameter int DATA_WIDTH   = 19,
    parameter int DATA_O_WIDTH = 8,
    parameter int MAX_DATA     = 254,
    parameter int CHANNEL_NUM  = 16,
    parameter int STRING_LEN   = 224
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mode_i,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    input  logic                         valid_i,
    input  logic                         sop_i,
    input  logic                         eop_i,
    input  logic                         sof_i,
    input  logic                         eof_i,
    output logic [DATA_O_WIDTH-1:0]      data_o,
    output logic                         data_valid_o,
    output logic                         sop_o,
    output logic                         eop_o,
    output logic                         sof_o,
    output logic                         eof_o,
    output logic                         frm_err_o
);
    localparam int SW    = DATA_O_WIDTH + 2;  // holds a sum of four samples
    localparam int DEPTH = STRING_LEN / 2 * CHANNEL_NUM;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
    localparam int COLW  = $clog2(STRING_LEN + 1);

    localparam logic [CW-1:0]                CH_LAST = CW'(CHANNEL_NUM - 1);
    localparam logic [COLW-1:0]              COL_END = COLW'(STRING_LEN);
    localparam logic signed [DATA_WIDTH-1:0] MAX_S   = DATA_WIDTH'(MAX_DATA);
    localparam logic [SW-1:0]                MAX_O   = SW'(MAX_DATA);

    typedef struct packed {
        logic          mode;
        logic          sop;
        logic          eop;
        logic          sof;
        logic          eof;
        logic [SW-1:0] h;
    } s1_t;

    function automatic logic [SW-1:0] combine(input logic m, input logic [SW-1:0] a,
                                              input logic [SW-1:0] b);
        return m ? (a + b) : ((a > b) ? a : b);
    endfunction

    // Control state
    logic [CW-1:0]   ch_cnt;
    logic [COLW-1:0] col_cnt;
    logic            row_odd, mode_q, in_line, frm_act, sof_pend;

    // Line storage; contents are don't-care after reset
    logic [DATA_O_WIDTH-1:0] hold [CHANNEL_NUM];
    logic [SW-1:0]           mem  [DEPTH];
    logic [SW-1:0]           rd_q;

    // Pipeline
    logic [1:0] vld_pipe;
    s1_t        s1_q, s1_d;
    logic       err_q, err_d;

    // Beats outside a frame are ignored until the next sof_i.
    logic act;
    logic [CW-1:0]   ch_e;
    logic [COLW-1:0] col_e;
    logic            row_e, mode_e, in_rng, eop_ok, pool_hit, sop_hit;
    logic [DATA_O_WIDTH-1:0] r;
    logic [SW-1:0]   h;
    logic [AW-1:0]   addr;

    assign act    = valid_i && (frm_act || sof_i);
    assign ch_e   = sop_i ? '0 : ch_cnt;
    assign col_e  = sop_i ? '0 : col_cnt;
    assign row_e  = sof_i ? 1'b0 : row_odd;
    assign mode_e = sof_i ? mode_i : mode_q;
    // Guards the buffer when a line overruns because eop_i never came.
    assign in_rng = col_e < COL_END;
    assign eop_ok = col_e[0] && (ch_e == CH_LAST);

    always_comb begin
        r = data_i[DATA_O_WIDTH-1:0];
        if (data_i[DATA_WIDTH-1])
            r = '0;
        else if (data_i > MAX_S)
            r = DATA_O_WIDTH'(MAX_DATA);
    end

    assign h        = combine(mode_e, SW'(hold[ch_e]), SW'(r));
    assign addr     = AW'(32'(col_e >> 1) * CHANNEL_NUM + 32'(ch_e));
    assign pool_hit = act && row_e && col_e[0] && in_rng;
    assign sop_hit  = pool_hit && (col_e == COLW'(1)) && (ch_e == '0);

    always_comb begin
        s1_d      = '0;
        s1_d.mode = mode_e;
        s1_d.sop  = sop_hit;
        s1_d.sof  = sop_hit && sof_pend;
        s1_d.eop  = pool_hit && eop_i && (ch_e == CH_LAST);
        s1_d.eof  = pool_hit && eop_i && (ch_e == CH_LAST) && eof_i;
        s1_d.h    = h;
        err_d     = act && ((eop_i && !eop_ok) || (eof_i && !row_e) || (sop_i && in_line));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_cnt   <= '0;
            col_cnt  <= '0;
            row_odd  <= 1'b0;
            mode_q   <= 1'b0;
            in_line  <= 1'b0;
            frm_act  <= 1'b0;
            sof_pend <= 1'b0;
        end else if (act) begin
            mode_q  <= mode_e;
            frm_act <= !eof_i;
            if (eop_i) begin
                // A line end always resyncs; a short line's pending hold is dropped.
                ch_cnt  <= '0;
                col_cnt <= '0;
                row_odd <= !row_e;
                in_line <= 1'b0;
            end else begin
                row_odd <= row_e;
                in_line <= in_line || sop_i;
                if (ch_e == CH_LAST) begin
                    ch_cnt  <= '0;
                    col_cnt <= col_e + COLW'(1);
                end else begin
                    ch_cnt  <= ch_e + CW'(1);
                    col_cnt <= col_e;
                end
            end
            if (sof_i)
                sof_pend <= 1'b1;
            else if (sop_hit)
                sof_pend <= 1'b0;
        end
    end

    // Storage without reset. Odd rows only read and even rows only write.
    always_ff @(posedge clk) begin
        if (act && !col_e[0])
            hold[ch_e] <= r;
        if (act && !row_e && col_e[0] && in_rng)
            mem[addr] <= h;
        if (pool_hit)
            rd_q <= mem[addr];
    end

    logic [SW-1:0] v, o;
    always_comb begin
        v = combine(s1_q.mode, rd_q, s1_q.h);
        o = s1_q.mode ? (v >> 2) : v;
        if (o > MAX_O)
            o = MAX_O;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe  <= '0;
            s1_q      <= '0;
            err_q     <= 1'b0;
            data_o    <= '0;
            sop_o     <= 1'b0;
            eop_o     <= 1'b0;
            sof_o     <= 1'b0;
            eof_o     <= 1'b0;
            frm_err_o <= 1'b0;
        end else begin
            vld_pipe  <= {vld_pipe[0], pool_hit};
            s1_q      <= s1_d;
            err_q     <= err_d;
            data_o    <= vld_pipe[0] ? o[DATA_O_WIDTH-1:0] : '0;
            sop_o     <= vld_pipe[0] && s1_q.sop;
            eop_o     <= vld_pipe[0] && s1_q.eop;
            sof_o     <= vld_pipe[0] && s1_q.sof;
            eof_o     <= vld_pipe[0] && s1_q.eof;
            frm_err_o <= err_q;
        end
    end

    assign data_valid_o = vld_pipe[1];

endmodule

// File: tb/tb_relu_pool2x2_v2.sv
// Bench for relu_pool2x2_v2 with C=2 channels and 4-pixel lines.
// The reference model keeps the ReLU'd input pixels of the current row pair.
// It pools each 2x2 block directly (max of four, or floor of the mean of four).
// The expected output word is scheduled into a time slot 2 clk after the beat.
// Every cycle the DUT outputs are compared with that slot.
module tb_relu_pool2x2_v2;
    localparam int C = 2, L = 4, DW = 19, DO = 8, MAXD = 254;

    logic clk = 0, reset = 1, mode_i = 0, valid_i = 0;
    logic sop_i = 0, eop_i = 0, sof_i = 0, eof_i = 0;
    logic signed [DW-1:0] data_i = '0;
    logic [DO-1:0] data_o;
    logic data_valid_o, sop_o, eop_o, sof_o, eof_o, frm_err_o;

    int errs = 0, checks = 0, cyc = 0;
    bit chk_on = 0, open_line = 0;
    logic [DO+5:0] exp_q [64];
    int pix  [2][L][C];
    int stim [2][L][C];
    logic [DO+5:0] obs;

    relu_pool2x2_v2 #(.DATA_WIDTH(DW), .DATA_O_WIDTH(DO), .MAX_DATA(MAXD),
                      .CHANNEL_NUM(C), .STRING_LEN(L)) dut (
        .clk(clk), .reset(reset), .mode_i(mode_i), .data_i(data_i), .valid_i(valid_i),
        .sop_i(sop_i), .eop_i(eop_i), .sof_i(sof_i), .eof_i(eof_i),
        .data_o(data_o), .data_valid_o(data_valid_o), .sop_o(sop_o), .eop_o(eop_o),
        .sof_o(sof_o), .eof_o(eof_o), .frm_err_o(frm_err_o));

    assign obs = {data_valid_o, sop_o, eop_o, sof_o, eof_o, frm_err_o, data_o};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %h want %h (cyc %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic int relu(input int d);
        if (d < 0) return 0;
        if (d > MAXD) return MAXD;
        return d;
    endfunction

    function automatic int pool(input bit md, input int a, input int b, input int c, input int d);
        int m;
        if (md) return (a + b + c + d) / 4;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // One clock: check this cycle's slot, then drive the next beat and schedule its result.
    task automatic tick(input bit v, input int d, input bit sop, input bit eop, input bit sof,
                        input bit eof, input bit md, input logic [DO+5:0] ev);
        @(negedge clk);
        if (chk_on) chk("out", 32'(obs), 32'(exp_q[cyc % 64]));
        exp_q[cyc % 64] = '0;
        valid_i = v; data_i = DW'(d); sop_i = sop; eop_i = eop;
        sof_i = sof; eof_i = eof; mode_i = md;
        exp_q[(cyc + 2) % 64] = ev;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 0, 0, 0, 0, 0, 0, '0);
    endtask

    // Drives one frame and schedules the expected output.
    // bad_row   : this row gets bad_len pixels.
    // cut_row   : this row is first cut after 2 pixels with no eop, then restarted.
    // stop_after: return after that many beats (-1 = whole frame).
    task automatic frame(input bit md, input int nrows, input int bad_row, input int bad_len,
                         input int cut_row, input bit dir, input int stop_after);
        int r = 0, nb = 0;
        bit first_out = 1, cut_done = 0, first_line = 1;
        while (r < nrows) begin
            bit cut;
            int len;
            cut = (r == cut_row) && !cut_done;
            len = cut ? 2 : ((r == bad_row) ? bad_len : L);
            for (int col = 0; col < len; col++) begin
                for (int ch = 0; ch < C; ch++) begin
                    int d, rv, val;
                    bit sop, eop, sof, eof, err, vo, so, eo, fo, ffo;
                    if (stop_after >= 0 && nb == stop_after) return;
                    d  = dir ? stim[r % 2][col][ch] : int'($urandom_range(0, 599)) - 300;
                    rv = relu(d);
                    sop = (col == 0 && ch == 0);
                    eop = (col == len - 1 && ch == C - 1) && !cut;
                    sof = sop && first_line;
                    eof = eop && (r == nrows - 1);
                    err = (eop && (len % 2 == 1)) || (eof && (r % 2 == 0)) || (sop && open_line);
                    vo = 0; so = 0; eo = 0; fo = 0; ffo = 0; val = 0;
                    if (r % 2 == 1 && col % 2 == 1) begin
                        vo  = 1;
                        val = pool(md, pix[0][col-1][ch], pix[0][col][ch], pix[1][col-1][ch], rv);
                        so  = (col == 1 && ch == 0);
                        fo  = so && first_out;
                        if (so) first_out = 0;
                        eo  = eop;
                        ffo = eop && eof;
                    end
                    pix[r % 2][col][ch] = rv;
                    if (sop) open_line = 1;
                    if (eop) open_line = 0;
                    if (!dir && $urandom_range(0, 4) == 0) idle(1);
                    tick(1, d, sop, eop, sof, eof, md, {vo, so, eo, fo, ffo, err, DO'(val)});
                    first_line = 0;
                    nb++;
                end
            end
            if (cut) cut_done = 1;
            else r++;
        end
    endtask

    task automatic fill(input int s0, input int s1);
        int c1 [2][4] = '{'{1, 5, 3, 2}, '{4, 0, 7, 9}};
        int c3 [2][4] = '{'{300, -5, 1, 2}, '{-5, -5, 3, 4}};
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) begin
                stim[r][c][0] = (s0 == 1) ? c1[r][c] : c3[r][c];
                stim[r][c][1] = (s1 == 1) ? -c1[r][c] : -(r * 4 + c + 1);
            end
    endtask

    initial begin
        foreach (exp_q[i]) exp_q[i] = '0;
        #1 chk("rst_init", 32'(obs), 32'h0);
        chk_on = 1;
        idle(3);
        reset = 0;
        idle(2);

        // Directed 2x4 frame in max mode, then the same frame in average mode.
        fill(1, 1);
        frame(0, 2, -1, 0, -1, 1, -1);
        idle(3);
        frame(1, 2, -1, 0, -1, 1, -1);
        idle(3);
        // Saturation and an all-negative block.
        fill(3, 3);
        frame(0, 2, -1, 0, -1, 1, -1);
        frame(1, 2, -1, 0, -1, 1, -1);
        idle(3);

        // Random 4-line frames with random pool modes.
        frame(0, 4, -1, 0, -1, 0, -1);
        for (int i = 0; i < 20; i++) begin
            frame(1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? 4 : 2, -1, 0, -1, 0, -1);
            if ($urandom_range(0, 1) != 0) idle(2);
        end
        idle(3);

        // Short line on row 1, then the next row pair must still pool correctly.
        frame(0, 4, 1, 3, -1, 0, -1);
        idle(3);
        // Line restarted with sop_i before its eop_i.
        frame(1, 2, -1, 0, 1, 0, -1);
        idle(3);
        // eof_i on row 2: error, no eof_o.
        frame(0, 3, -1, 0, -1, 0, -1);
        idle(3);

        // Reset mid-row while a pooled beat is on the outputs.
        fill(1, 1);
        frame(0, 2, -1, 0, -1, 1, 12);
        @(posedge clk);
        #2;
        chk("pre_rst_vld", 32'(data_valid_o), 32'h1);
        reset = 1;
        foreach (exp_q[i]) exp_q[i] = '0;
        open_line = 0;
        #1 chk("rst_mid", 32'(obs), 32'h0);
        idle(2);
        reset = 0;
        // Stray beats without sof_i are ignored.
        for (int i = 0; i < 4; i++) tick(1, i + 20, 0, 0, 0, 0, 0, '0);
        idle(2);
        frame(0, 2, -1, 0, -1, 1, -1);
        idle(2);
        frame(1, 4, -1, 0, -1, 0, -1);
        idle(4);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
